// File: rtl/cpu_power_sequencer_if.sv
// Signal bundle between cpld_top glue and the CPU power sequencer.
// The master side drives the DSP-ready and CPU RESETOUT inputs; the slave side drives the PMIC/reset controls and status.
interface cpu_power_sequencer_if;
    logic       dsp_ready;
    logic       cpu_resetout;
    logic       pmic_pwron_drive;
    logic       cpu_reset_hold;
    logic       usbhub_reset_INV;
    logic       cpu_running;
    logic       fault;
    logic [2:0] state;
    logic [1:0] retry_count;

    modport master (
        output dsp_ready, cpu_resetout,
        input  pmic_pwron_drive, cpu_reset_hold, usbhub_reset_INV,
               cpu_running, fault, state, retry_count
    );

    modport slave (
        input  dsp_ready, cpu_resetout,
        output pmic_pwron_drive, cpu_reset_hold, usbhub_reset_INV,
               cpu_running, fault, state, retry_count
    );
endinterface

// File: rtl/cpu_power_sequencer.sv
// CPU power-up sequencer: settles on DSP ready, pulses PMIC PWRON, watches RESETOUT
// with a bounded retry/backoff loop, then releases the USB hub. Outputs are Moore decodes of state.
module cpu_power_sequencer #(
    parameter logic [15:0] DSP_SETTLE   = 16'd4096,
    parameter logic [23:0] PWRON_PULSE  = 24'd40000,
    parameter logic [23:0] BOOT_TIMEOUT = 24'd8000000,
    parameter logic [23:0] HUB_RESET    = 24'd50000,
    parameter logic [23:0] BACKOFF      = 24'd400000,
    parameter logic [1:0]  MAX_RETRIES  = 2'd2
) (
    input  logic                  sysclk,
    input  logic                  reset,
    cpu_power_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTLE    = 3'd1,
        S_PWRON     = 3'd2,
        S_WAIT_BOOT = 3'd3,
        S_HUB_RST   = 3'd4,
        S_RUN       = 3'd5,
        S_BACKOFF   = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [23:0] SETTLE_LAST  = 24'(DSP_SETTLE) - 24'd1;
    localparam logic [23:0] PWRON_LAST   = PWRON_PULSE - 24'd1;
    localparam logic [23:0] BOOT_LAST    = BOOT_TIMEOUT - 24'd1;
    localparam logic [23:0] HUB_LAST     = HUB_RESET - 24'd1;
    localparam logic [23:0] BACKOFF_LAST = BACKOFF - 24'd1;

    state_t      st, st_nxt;
    logic [23:0] cnt, cnt_nxt;
    logic [1:0]  retry, retry_nxt;
    logic        rs_meta, rs;
    logic        timed;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            st      <= S_IDLE;
            cnt     <= '0;
            retry   <= '0;
            rs_meta <= 1'b0;
            rs      <= 1'b0;
        end else begin
            st      <= st_nxt;
            cnt     <= cnt_nxt;
            retry   <= retry_nxt;
            rs_meta <= bus.cpu_resetout;
            rs      <= rs_meta;
        end
    end

    always_comb begin
        st_nxt    = st;
        retry_nxt = retry;
        if (st != S_IDLE && !bus.dsp_ready) begin
            st_nxt    = S_IDLE;
            retry_nxt = '0;
        end else begin
            case (st)
                S_IDLE:      if (bus.dsp_ready) st_nxt = S_SETTLE;
                S_SETTLE:    if (cnt == SETTLE_LAST) st_nxt = S_PWRON;
                S_PWRON:     if (cnt == PWRON_LAST) st_nxt = S_WAIT_BOOT;
                S_WAIT_BOOT: begin
                    // A boot seen on the timeout edge still counts as a boot.
                    if (rs) begin
                        st_nxt = S_HUB_RST;
                    end else if (cnt == BOOT_LAST) begin
                        if (retry < MAX_RETRIES) begin
                            st_nxt    = S_BACKOFF;
                            retry_nxt = retry + 2'd1;
                        end else begin
                            st_nxt = S_FAULT;
                        end
                    end
                end
                S_HUB_RST: begin
                    if (!rs)                  st_nxt = S_WAIT_BOOT;
                    else if (cnt == HUB_LAST) st_nxt = S_RUN;
                end
                S_RUN:       if (!rs) st_nxt = S_WAIT_BOOT;
                S_BACKOFF:   if (cnt == BACKOFF_LAST) st_nxt = S_PWRON;
                default:     st_nxt = st;
            endcase
        end

        // Counter only runs in timed states, so it cannot wrap while parked in RUN/FAULT.
        timed = (st == S_SETTLE) || (st == S_PWRON) || (st == S_WAIT_BOOT) ||
                (st == S_HUB_RST) || (st == S_BACKOFF);
        if (st_nxt != st || !timed) cnt_nxt = '0;
        else                        cnt_nxt = cnt + 24'd1;
    end

    assign bus.pmic_pwron_drive = (st == S_PWRON);
    assign bus.cpu_reset_hold   = (st == S_IDLE) || (st == S_SETTLE) || (st == S_PWRON) ||
                                  (st == S_BACKOFF) || (st == S_FAULT);
    assign bus.usbhub_reset_INV = (st == S_RUN);
    assign bus.cpu_running      = (st == S_RUN);
    assign bus.fault            = (st == S_FAULT);
    assign bus.state            = st;
    assign bus.retry_count      = retry;

endmodule

// File: tb/tb_cpu_power_sequencer.sv
// Bench for cpu_power_sequencer: directed scenarios with literal expectations, then random
// stimulus, all compared every cycle against a countdown-based reference model.
module tb_cpu_power_sequencer;

    localparam int P_SETTLE = 4;
    localparam int P_PWRON  = 3;
    localparam int P_BOOT   = 20;
    localparam int P_HUB    = 5;
    localparam int P_BACK   = 6;
    localparam int P_RETRY  = 2;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #5 sysclk = ~sysclk;

    cpu_power_sequencer_if bus();

    cpu_power_sequencer #(
        .DSP_SETTLE  (16'(P_SETTLE)),
        .PWRON_PULSE (24'(P_PWRON)),
        .BOOT_TIMEOUT(24'(P_BOOT)),
        .HUB_RESET   (24'(P_HUB)),
        .BACKOFF     (24'(P_BACK)),
        .MAX_RETRIES (2'(P_RETRY))
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase number plus cycles remaining in the current timed phase.
    int   m_ph    = 0;
    int   m_rem   = 0;
    int   m_retry = 0;
    logic m_meta  = 1'b0;
    logic m_rs    = 1'b0;
    bit   m_valid = 1'b0;

    function automatic int dur(input int ph);
        case (ph)
            1:       return P_SETTLE;
            2:       return P_PWRON;
            3:       return P_BOOT;
            4:       return P_HUB;
            6:       return P_BACK;
            default: return 0;
        endcase
    endfunction

    always @(posedge sysclk) begin : model
        int ph, nxt, rem, rt;
        logic rs_seen;
        if (reset) begin
            m_ph    <= 0;
            m_rem   <= 0;
            m_retry <= 0;
            m_meta  <= 1'b0;
            m_rs    <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            ph      = m_ph;
            rem     = m_rem;
            rt      = m_retry;
            rs_seen = m_rs;
            nxt     = ph;
            if (ph != 0 && !bus.dsp_ready) begin
                nxt = 0;
                rt  = 0;
            end else begin
                if (rem > 0) rem = rem - 1;
                case (ph)
                    0: if (bus.dsp_ready) nxt = 1;
                    1: if (rem == 0) nxt = 2;
                    2: if (rem == 0) nxt = 3;
                    3: begin
                        if (rs_seen)          nxt = 4;
                        else if (rem == 0) begin
                            if (rt < P_RETRY) begin nxt = 6; rt = rt + 1; end
                            else              nxt = 7;
                        end
                    end
                    4: begin
                        if (!rs_seen)      nxt = 3;
                        else if (rem == 0) nxt = 5;
                    end
                    5: if (!rs_seen) nxt = 3;
                    6: if (rem == 0) nxt = 2;
                    default: nxt = ph;
                endcase
            end
            if (nxt != ph) rem = dur(nxt);
            m_ph    <= nxt;
            m_rem   <= rem;
            m_retry <= rt;
            m_rs    <= m_meta;
            m_meta  <= bus.cpu_resetout;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge sysclk) begin
        logic [9:0] exp_v, act_v;
        if (m_valid) begin
            exp_v = {3'(m_ph), 2'(m_retry), (m_ph == 2),
                     (m_ph == 0 || m_ph == 1 || m_ph == 2 || m_ph == 6 || m_ph == 7),
                     (m_ph == 5), (m_ph == 5), (m_ph == 7)};
            act_v = {bus.state, bus.retry_count, bus.pmic_pwron_drive, bus.cpu_reset_hold,
                     bus.usbhub_reset_INV, bus.cpu_running, bus.fault};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t got=%b want=%b (state,retry,pwron,hold,usb,run,fault)",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic chk_st(input string nm, input int st);
        chk(nm, int'(bus.state), st);
    endtask

    initial begin
        bus.dsp_ready    = 1'b0;
        bus.cpu_resetout = 1'b0;
        reset = 1'b1;
        tick(2);
        chk_st("rst_state", 0);
        chk("rst_hold", bus.cpu_reset_hold, 1);
        chk("rst_pwron", bus.pmic_pwron_drive, 0);
        chk("rst_usb", bus.usbhub_reset_INV, 0);
        chk("rst_run", bus.cpu_running, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_retry", bus.retry_count, 0);

        // Nominal power-up
        reset = 1'b0;
        bus.dsp_ready = 1'b1;
        tick(1); chk_st("nom_settle@1", 1);
        tick(4); chk_st("nom_pwron@5", 2); chk("nom_pwron_drv@5", bus.pmic_pwron_drive, 1);
        tick(2); chk("nom_pwron_drv@7", bus.pmic_pwron_drive, 1);
        tick(1); chk_st("nom_wait@8", 3); chk("nom_hold@8", bus.cpu_reset_hold, 0);
        chk("nom_pwron_off@8", bus.pmic_pwron_drive, 0);
        bus.cpu_resetout = 1'b1;
        tick(4); chk_st("nom_hub@12", 4);
        tick(5); chk_st("nom_run@17", 5);
        chk("nom_usb", bus.usbhub_reset_INV, 1); chk("nom_running", bus.cpu_running, 1);

        // CPU self-reboot from RUN
        bus.cpu_resetout = 1'b0;
        tick(2); chk_st("reboot_still_run", 5);
        tick(1); chk_st("reboot_wait", 3);
        chk("reboot_usb", bus.usbhub_reset_INV, 0); chk("reboot_hold", bus.cpu_reset_hold, 0);

        // One timeout then successful boot
        tick(20); chk_st("to1_backoff", 6); chk("to1_retry", bus.retry_count, 1);
        chk("to1_hold", bus.cpu_reset_hold, 1);
        tick(6); chk_st("to1_pwron", 2);
        tick(3); chk_st("to1_wait", 3);
        bus.cpu_resetout = 1'b1;
        tick(3); chk_st("to1_hub", 4);
        tick(5); chk_st("to1_run", 5); chk("to1_run_retry", bus.retry_count, 1);

        // Retries exhausted -> sticky fault
        bus.cpu_resetout = 1'b0;
        tick(3); chk_st("ex_wait", 3);
        tick(20); chk_st("ex_backoff", 6); chk("ex_retry2", bus.retry_count, 2);
        tick(6); chk_st("ex_pwron", 2);
        tick(3); chk_st("ex_wait2", 3);
        tick(20); chk_st("ex_fault", 7); chk("ex_fault_o", bus.fault, 1);
        chk("ex_fault_retry", bus.retry_count, 2);
        tick(100); chk_st("ex_fault_sticky", 7);
        bus.dsp_ready = 1'b0;
        tick(1); chk_st("ex_idle", 0); chk("ex_retry_clr", bus.retry_count, 0);

        // dsp_ready dropout mid-PWRON
        bus.dsp_ready = 1'b1;
        tick(1); chk_st("drop_settle", 1);
        tick(5); chk_st("drop_mid_pwron", 2);
        bus.dsp_ready = 1'b0;
        tick(1); chk_st("drop_idle", 0);
        chk("drop_pwron_off", bus.pmic_pwron_drive, 0); chk("drop_hold", bus.cpu_reset_hold, 1);
        bus.dsp_ready = 1'b1;
        tick(1); chk_st("drop_resettle", 1);
        tick(3); chk_st("drop_full_settle", 1);
        tick(1); chk_st("drop_pwron", 2);

        // Boot seen on the timeout edge wins
        tick(3); chk_st("race_wait", 3);
        tick(17);
        bus.cpu_resetout = 1'b1;
        tick(2); chk_st("race_wait19", 3);
        tick(1); chk_st("race_hub", 4); chk("race_retry", bus.retry_count, 0);
        tick(5); chk_st("race_run", 5);

        // Synchronous reset mid-RUN
        reset = 1'b1;
        tick(1);
        chk_st("rrun_state", 0); chk("rrun_hold", bus.cpu_reset_hold, 1);
        chk("rrun_usb", bus.usbhub_reset_INV, 0); chk("rrun_running", bus.cpu_running, 0);
        chk("rrun_retry", bus.retry_count, 0);
        reset = 1'b0;

        // Random soak against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) bus.cpu_resetout = ~bus.cpu_resetout;
            if (bus.dsp_ready) begin
                if ($urandom_range(0, 299) == 0) bus.dsp_ready = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.dsp_ready = 1'b1;
            end
            reset = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
